// File: rtl/switchbox_config_loader_if.sv
// Streaming word handshake between a configuration source and the switchbox
// configuration loader.
interface switchbox_config_loader_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/switchbox_config_loader.sv
// Assembles streamed words into a shadow image, verifies an XOR check word,
// then commits the image to the live SwitchBox configuration in one cycle.
module switchbox_config_loader #(
  parameter int unsigned CONFIG_WIDTH = 112,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    abort,
  switchbox_config_loader_if.slave cfg,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ERROR} state_t;

  state_t                          state, state_next;
  logic [NUM_WORDS*WORD_WIDTH-1:0] shadow;
  logic [CNT_W-1:0]                count;
  logic [WORD_WIDTH-1:0]           parity;
  logic                            launch, xfer, last_word, check_ok;

  assign launch         = start && ((state == IDLE) || (state == ERROR));
  assign cfg.data_ready = (state == LOAD) || (state == CHECK);
  assign busy           = cfg.data_ready;
  // abort outranks a same-cycle transfer, so the word is never counted
  assign xfer           = cfg.data_ready && cfg.data_valid && !abort;
  assign last_word      = (count == CNT_W'(NUM_WORDS - 1));
  assign check_ok       = (cfg.data_in == parity);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, ERROR: if (start) state_next = LOAD;
      LOAD: begin
        if (abort)                  state_next = IDLE;
        else if (xfer && last_word) state_next = CHECK;
      end
      CHECK: begin
        if (abort)     state_next = IDLE;
        else if (xfer) state_next = check_ok ? IDLE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shadow       <= '0;
      count        <= '0;
      parity       <= '0;
      config_out   <= '0;
      config_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        count  <= '0;
        parity <= '0;
        error  <= 1'b0;
      end else if (state == LOAD && xfer) begin
        // words past CONFIG_WIDTH land in the padding bits and are dropped at commit
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
          if (count == CNT_W'(k)) shadow[k*WORD_WIDTH +: WORD_WIDTH] <= cfg.data_in;
        end
        parity <= parity ^ cfg.data_in;
        count  <= count + 1'b1;
      end else if (state == CHECK && xfer) begin
        if (check_ok) begin
          config_out   <= shadow[CONFIG_WIDTH-1:0];
          config_valid <= 1'b1;
          done         <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_switchbox_config_loader.sv
// Directed and randomized checks of the configuration loader against a
// word-array reference model of the expected image and check word.
module tb_switchbox_config_loader;
  logic         clock = 1'b0;
  logic         nreset = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic [111:0] config_out;
  logic         config_valid, busy, done, error;

  logic         start2 = 1'b0, abort2 = 1'b0;
  logic [11:0]  config_out2;
  logic         config_valid2, busy2, done2, error2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   words [14];
  logic [111:0] model_cfg   = '0;
  logic         model_valid = 1'b0;

  switchbox_config_loader_if #(.WORD_WIDTH(8)) bus ();
  switchbox_config_loader_if #(.WORD_WIDTH(8)) bus2 ();

  switchbox_config_loader #(.CONFIG_WIDTH(112), .WORD_WIDTH(8)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort), .cfg(bus),
    .config_out(config_out), .config_valid(config_valid), .busy(busy),
    .done(done), .error(error)
  );

  switchbox_config_loader #(.CONFIG_WIDTH(12), .WORD_WIDTH(8)) dut_narrow (
    .clock(clock), .nreset(nreset), .start(start2), .abort(abort2), .cfg(bus2),
    .config_out(config_out2), .config_valid(config_valid2), .busy(busy2),
    .done(done2), .error(error2)
  );

  always #5 clock = ~clock;

  function automatic logic [111:0] image();
    logic [111:0] v;
    v = '0;
    for (int k = 0; k < 14; k++) v[k*8 +: 8] = words[k];
    return v;
  endfunction

  function automatic logic [7:0] xor_of_words();
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 14; k++) x = x ^ words[k];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("error_after_start", error, 0);
  endtask

  task automatic send(input logic [7:0] w, input bit stall);
    int n;
    n = stall ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < n; i++) begin
      bus.data_valid = 1'b0;
      bus.data_in    = 8'($urandom);
      step();
      chk("ready_in_stall", bus.data_ready, 1);
      chk("cfg_stable_in_stall", config_out, model_cfg);
      chk("done_low_in_stall", done, 0);
    end
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic expect_commit(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cfg"}, config_out, model_cfg);
    chk({tag, "_valid"}, config_valid, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    bus.data_in = '0;  bus.data_valid = 1'b0;
    bus2.data_in = '0; bus2.data_valid = 1'b0;
    #12;
    chk("rst_cfg", config_out, 0);
    chk("rst_valid", config_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.data_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    nreset = 1'b1;
    step();

    // nominal load
    for (int k = 0; k < 14; k++) words[k] = 8'(k + 1);
    begin_load();
    for (int k = 0; k < 14; k++) send(words[k], 0);
    send(8'h0F, 0);
    model_cfg = 112'h0E0D0C0B0A090807060504030201;
    model_valid = 1'b1;
    expect_commit("nominal");

    // bad check word, directly back-to-back with the previous done
    begin_load();
    for (int k = 0; k < 14; k++) send(words[k], 0);
    send(8'h00, 0);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_cfg", config_out, model_cfg);
    step();
    chk("bad_error_held", error, 1);
    chk("bad_done_held", done, 0);
    abort = 1'b1;
    step();
    chk("err_abort_noeffect", error, 1);
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("err_start_wins_busy", busy, 1);
    chk("err_start_clears", error, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_from_load_idle", busy, 0);
    bus.data_valid = 1'b1;
    #1;
    chk("idle_ready_low", bus.data_ready, 0);
    bus.data_valid = 1'b0;

    // randomized loads with stalls, good and corrupted check words
    for (int r = 0; r < 4; r++) begin
      bit good;
      logic [7:0] cw;
      good = (r != 2);
      for (int k = 0; k < 14; k++) words[k] = 8'($urandom);
      cw = good ? xor_of_words() : (xor_of_words() ^ 8'($urandom_range(1, 255)));
      begin_load();
      for (int k = 0; k < 14; k++) send(words[k], 1);
      send(cw, 1);
      if (good) begin
        model_cfg = image();
        expect_commit("rand");
      end else begin
        chk("rand_bad_error", error, 1);
        chk("rand_bad_done", done, 0);
        chk("rand_bad_cfg", config_out, model_cfg);
        chk("rand_bad_valid", config_valid, model_valid);
      end
    end

    // abort after word 5
    for (int k = 0; k < 14; k++) words[k] = 8'($urandom);
    begin_load();
    for (int k = 0; k <= 5; k++) send(words[k], 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_cfg", config_out, model_cfg);
    chk("abort_valid", config_valid, 1);

    // abort in the same cycle as word 7
    begin_load();
    for (int k = 0; k <= 6; k++) send(words[k], 0);
    abort = 1'b1;
    send(words[7], 0);
    abort = 1'b0;
    chk("abort_prio_busy", busy, 0);
    chk("abort_prio_done", done, 0);
    chk("abort_prio_cfg", config_out, model_cfg);

    // start during a load must not restart it
    begin_load();
    for (int k = 0; k <= 6; k++) send(words[k], 0);
    start = 1'b1;
    send(words[7], 0);
    start = 1'b0;
    for (int k = 8; k < 14; k++) send(words[k], 1);
    send(xor_of_words(), 0);
    model_cfg = image();
    expect_commit("start_ignored");

    // reset mid-load, then a fresh load
    for (int k = 0; k < 14; k++) words[k] = 8'($urandom);
    begin_load();
    for (int k = 0; k <= 9; k++) send(words[k], 0);
    nreset = 1'b0;
    #2;
    chk("midrst_cfg", config_out, 0);
    chk("midrst_valid", config_valid, 0);
    chk("midrst_busy", busy, 0);
    model_cfg = '0;
    #3 nreset = 1'b1;
    step();
    begin_load();
    for (int k = 0; k < 14; k++) send(words[k], 1);
    send(xor_of_words(), 1);
    model_cfg = image();
    expect_commit("after_rst");

    // 12-bit configuration with 8-bit words
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("narrow_busy", busy2, 1);
    bus2.data_valid = 1'b1;
    bus2.data_in = 8'hAB; step();
    bus2.data_in = 8'hCD; step();
    bus2.data_in = 8'h66; step();
    bus2.data_valid = 1'b0;
    chk("narrow_done", done2, 1);
    chk("narrow_cfg", config_out2, 12'hDAB);
    chk("narrow_valid", config_valid2, 1);
    step();
    chk("narrow_done_pulse", done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/switchbox_config_loader.md
Name: switchbox_config_loader

Overview:
Loads the 112-bit configuration word that drives a SwitchBox's routing and LE-input multiplexers. A configuration source streams it in as WORD_WIDTH-bit words over a valid/ready handshake. The block assembles the words in a shadow register, verifies an XOR check word, and only then commits the image atomically to the live configuration. The SwitchBox therefore never sees a partially written routing pattern.

Parameters:
CONFIG_WIDTH, 112, width of the SwitchBox configuration vector
WORD_WIDTH, 8, width of one streamed configuration word
NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH) (14), data words per load; derived, not overridden

Ports:
clock  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  begin a load; sampled only in IDLE or ERROR
abort  in  1  cancel the load in progress
data_in  in  WORD_WIDTH  configuration word or check word
data_valid  in  1  data_in valid
data_ready  out  1  block accepts data_in this cycle
config_out  out  CONFIG_WIDTH  live configuration, connects to SwitchBox config_in
config_valid  out  1  config_out holds a committed, verified image
busy  out  1  load in progress (LOAD or CHECK)
done  out  1  one-cycle pulse on successful commit
error  out  1  check-word mismatch; held until next start

Behaviour:
- Reset (nreset low, asynchronous): state=IDLE; config_out=0; config_valid=0; shadow=0; word counter=0; running XOR=0; data_ready=busy=done=error=0.
- States: IDLE, LOAD, CHECK, ERROR. Registered outputs; transfers happen on rising edge where data_valid&&data_ready.
- IDLE/ERROR + start: go to LOAD; clear counter, running XOR and error. Shadow is not cleared, but every bit below CONFIG_WIDTH is overwritten before commit.
- LOAD:
  - data_ready=1, busy=1.
  - Word k (k=0..NUM_WORDS-1) is written to shadow bits [k*WORD_WIDTH +: WORD_WIDTH].
  - Bits at or above CONFIG_WIDTH are discarded; they are still included in the XOR.
  - Running XOR ^= data_in; counter increments.
  - On acceptance of word NUM_WORDS-1, go to CHECK.
- CHECK:
  - data_ready=1, busy=1.
  - On the transfer, compare data_in with the running XOR.
  - Equal: next cycle config_out<=shadow[CONFIG_WIDTH-1:0], config_valid<=1, done=1 for exactly that cycle, state=IDLE.
  - Unequal: state=ERROR, error=1; config_out and config_valid unchanged.
- data_valid low in LOAD/CHECK: no progress, no timeout; the stream may stall indefinitely.
- abort while in LOAD or CHECK:
  - Next state IDLE; load discarded; config_out and config_valid unchanged; error not set.
  - abort has priority over a same-cycle transfer; the word is not counted.
- abort in IDLE/ERROR: no effect.
- start while busy: ignored.
- start and abort in the same cycle in IDLE/ERROR: start wins.
- data_valid outside LOAD/CHECK: ignored (data_ready=0).
- config_out changes only on a successful commit or reset. It never changes during LOAD/CHECK/ERROR.
- Latency: minimum NUM_WORDS+1 transfer cycles after start, then done in the following cycle. Back-to-back loads are allowed: start is accepted in the cycle after done.
- nreset asserted mid-load: immediate return to reset values, including config_out=0 and config_valid=0.

Test Plan:
- Nominal load: start; words 0x01..0x0E on consecutive cycles; check word 0x0F -> done pulses once; config_out=0x0E0D0C0B0A090807060504030201; config_valid=1; busy low.
- Bad check: same words, check word 0x00 -> error=1, done never pulses, config_out keeps its previous value; then start -> error clears.
- Stalls and abort: toggle data_valid pseudo-randomly -> data_ready high only in LOAD/CHECK and the result matches nominal. Assert abort after word 5 -> IDLE, config_out unchanged, no done/error.
- Abort priority: abort in the same cycle as a valid word 7 -> word not counted, IDLE.
- Reset mid-load: pull nreset low after word 9 of a second load -> config_out=0 and config_valid=0 immediately. A fresh full load then succeeds.
- Non-divisible width: CONFIG_WIDTH=12, WORD_WIDTH=8; words 0xAB, 0xCD; check 0x66 -> config_out=0xDAB.
